// File: rtl/patient_dispatch_scheduler_pkg.sv
// Shared types for the patient dispatch scheduler: query codes, doctor codes,
// the waiting-queue entry and the doctor-eligibility rule.
package patient_sched_pkg;

  localparam int PSCHED_ID_W = 4;

  typedef enum logic [1:0] {
    Q_GEN    = 2'b00,  // doctor A only
    Q_PREF_A = 2'b01,  // A preferred, else B
    Q_PREF_B = 2'b10,  // B preferred, else A
    Q_SPEC_B = 2'b11   // doctor B only
  } query_t;

  typedef enum logic [1:0] {
    DOC_NONE = 2'b00,
    DOC_A    = 2'b01,
    DOC_B    = 2'b10
  } doc_t;

  typedef struct packed {
    query_t                 query;
    logic [PSCHED_ID_W-1:0] id;
  } entry_t;

  // Picks the doctor a patient with query q may see, given which doctors are free.
  function automatic doc_t pick_doc(query_t q, logic free_a, logic free_b);
    doc_t d;
    d = DOC_NONE;
    case (q)
      Q_GEN:    if (free_a) d = DOC_A;
      Q_PREF_A: begin
        if (free_a)      d = DOC_A;
        else if (free_b) d = DOC_B;
      end
      Q_PREF_B: begin
        if (free_b)      d = DOC_B;
        else if (free_a) d = DOC_A;
      end
      Q_SPEC_B: if (free_b) d = DOC_B;
      default:  d = DOC_NONE;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/patient_dispatch_scheduler_if.sv
// Kiosk request handshake and doctor-assignment bus of the dispatch scheduler.
// master = kiosk/display side, slave = scheduler.
interface patient_dispatch_scheduler_if #(
  parameter int ID_W = 4
) ();

  logic [1:0]        req_valid;
  logic [3:0]        req_query;
  logic [2*ID_W-1:0] req_id;
  logic [1:0]        req_ready;
  logic              assign_valid;
  logic [1:0]        assign_doc;
  logic [ID_W-1:0]   assign_id;

  modport master (
    output req_valid, req_query, req_id,
    input  req_ready, assign_valid, assign_doc, assign_id
  );

  modport slave (
    input  req_valid, req_query, req_id,
    output req_ready, assign_valid, assign_doc, assign_id
  );

endinterface

// File: rtl/patient_dispatch_scheduler_consult_timer.sv
// Consultation timer for one doctor: loads CONSULT_CYCLES on assignment,
// counts down to zero, can be cleared early by a release. busy = timer != 0.
module consult_timer #(
  parameter int CONSULT_CYCLES = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic rel,
  output logic busy
);

  localparam int TW = $clog2(CONSULT_CYCLES + 1);

  logic [TW-1:0] timer_d, timer_q;

  // Next timer value: load wins (only issued when idle), then release, then countdown.
  always_comb begin
    timer_d = timer_q;
    if (load)                timer_d = TW'(CONSULT_CYCLES);
    else if (rel)            timer_d = '0;
    else if (timer_q != '0)  timer_d = timer_q - TW'(1);
  end

  // Timer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) timer_q <= '0;
    else        timer_q <= timer_d;
  end

  assign busy = (timer_q != '0);

endmodule

// File: rtl/patient_dispatch_scheduler.sv
// Patient dispatch scheduler: round-robin admission from two kiosks into an
// in-order waiting queue, head-of-queue dispatch onto doctor A or B, and one
// consult_timer per doctor. Optional statistics outputs under `SCHED_STATS_EN.
module patient_dispatch_scheduler
  import patient_sched_pkg::*;
#(
  parameter int DEPTH          = 8,
  parameter int CONSULT_CYCLES = 15,
  parameter int ID_W           = PSCHED_ID_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  patient_dispatch_scheduler_if.slave bus,
  input  logic [1:0]               doc_release,
  output logic [1:0]               doc_busy,
  output logic [$clog2(DEPTH):0]   q_count,
  output logic                     q_full,
  output logic                     q_empty
`ifdef SCHED_STATS_EN
  ,
  output logic [15:0]              served_a,
  output logic [15:0]              served_b,
  output logic [$clog2(DEPTH):0]   max_occ
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    query_t          query;
    logic [ID_W-1:0] id;
  } slot_t;

  slot_t           queue_mem [DEPTH];
  logic [AW-1:0]   wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
  logic [CW-1:0]   count_d, count_q;
  logic            rr_d, rr_q;          // 0: kiosk0 wins a tie, 1: kiosk1 wins
  logic            assign_valid_d, assign_valid_q;
  doc_t            assign_doc_d, assign_doc_q;
  logic [ID_W-1:0] assign_id_d, assign_id_q;

  logic [1:0]      grant;
  logic            push, pop, push_kiosk, full, empty;
  slot_t           new_slot, head;
  doc_t            pick;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // Round-robin grant; nothing is granted while the registered count says full.
  always_comb begin
    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    grant = 2'b00;
    if (!full) begin
      case (bus.req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = rr_q ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  assign push       = |grant;
  assign push_kiosk = grant[1];

  // Entry written on a push, taken from the granted kiosk.
  always_comb begin
    new_slot.query = query_t'(push_kiosk ? bus.req_query[3:2] : bus.req_query[1:0]);
    new_slot.id    = push_kiosk ? bus.req_id[2*ID_W-1:ID_W] : bus.req_id[ID_W-1:0];
  end

  assign head = queue_mem[rd_ptr_q];

  // Dispatch decision on registered state; an ineligible head blocks everything behind it.
  always_comb begin
    pick = DOC_NONE;
    if (!empty) pick = pick_doc(head.query, !doc_busy[0], !doc_busy[1]);
  end

  assign pop = (pick != DOC_NONE);

  // Queue pointers, occupancy, RR pointer and the one-cycle assignment pulse.
  always_comb begin
    wr_ptr_d       = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d       = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d        = count_q + CW'(push) - CW'(pop);
    rr_d           = push ? !push_kiosk : rr_q;
    assign_valid_d = pop;
    assign_doc_d   = pick;
    assign_id_d    = pop ? head.id : '0;
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      rr_q           <= 1'b0;
      assign_valid_q <= 1'b0;
      assign_doc_q   <= DOC_NONE;
      assign_id_q    <= '0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      rr_q           <= rr_d;
      assign_valid_q <= assign_valid_d;
      assign_doc_q   <= assign_doc_d;
      assign_id_q    <= assign_id_d;
    end
  end

  // Queue storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is not reset; count and pointers define which slots are valid.
    if (push) queue_mem[wr_ptr_q] <= new_slot;
  end

  consult_timer #(.CONSULT_CYCLES(CONSULT_CYCLES)) u_timer_a (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (pick == DOC_A),
    .rel   (doc_release[0]),
    .busy  (doc_busy[0])
  );

  consult_timer #(.CONSULT_CYCLES(CONSULT_CYCLES)) u_timer_b (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (pick == DOC_B),
    .rel   (doc_release[1]),
    .busy  (doc_busy[1])
  );

  assign bus.req_ready    = grant;
  assign bus.assign_valid = assign_valid_q;
  assign bus.assign_doc   = assign_doc_q;
  assign bus.assign_id    = assign_id_q;
  assign q_count          = count_q;
  assign q_full           = full;
  assign q_empty          = empty;

`ifdef SCHED_STATS_EN
  logic [15:0]   served_a_d, served_a_q, served_b_d, served_b_q;
  logic [CW-1:0] max_occ_d, max_occ_q;

  // Saturating per-doctor assignment counters and peak occupancy.
  always_comb begin
    served_a_d = served_a_q;
    served_b_d = served_b_q;
    if (pick == DOC_A && served_a_q != 16'hFFFF) served_a_d = served_a_q + 16'd1;
    if (pick == DOC_B && served_b_q != 16'hFFFF) served_b_d = served_b_q + 16'd1;
    max_occ_d = (count_d > max_occ_q) ? count_d : max_occ_q;
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      served_a_q <= '0;
      served_b_q <= '0;
      max_occ_q  <= '0;
    end else begin
      served_a_q <= served_a_d;
      served_b_q <= served_b_d;
      max_occ_q  <= max_occ_d;
    end
  end

  assign served_a = served_a_q;
  assign served_b = served_b_q;
  assign max_occ  = max_occ_q;
`endif

endmodule

// File: tb/tb_patient_dispatch_scheduler.sv
// Self-checking bench for patient_dispatch_scheduler: directed scenarios plus
// randomized traffic against a queue-based reference model; assignments are
// checked by a scoreboard monitor. Honors `SCHED_STATS_EN when defined.
module tb_patient_dispatch_scheduler;
  import patient_sched_pkg::*;

  localparam int DEPTH = 8;
  localparam int CC    = 15;
  localparam int ID_W  = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    doc_release = 2'b00;
  logic [1:0]    doc_busy;
  logic [CW-1:0] q_count;
  logic          q_full, q_empty;
`ifdef SCHED_STATS_EN
  logic [15:0]   served_a, served_b;
  logic [CW-1:0] max_occ;
`endif

  patient_dispatch_scheduler_if #(.ID_W(ID_W)) bus ();

  patient_dispatch_scheduler #(.DEPTH(DEPTH), .CONSULT_CYCLES(CC), .ID_W(ID_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .doc_release (doc_release),
    .doc_busy    (doc_busy),
    .q_count     (q_count),
    .q_full      (q_full),
    .q_empty     (q_empty)
`ifdef SCHED_STATS_EN
    ,
    .served_a    (served_a),
    .served_b    (served_b),
    .max_occ     (max_occ)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard of expected assignments, tagged with the cycle they must appear in.
  typedef struct {
    int              cyc;
    logic [1:0]      doc;
    logic [ID_W-1:0] id;
  } exp_t;
  exp_t sb[$];

  // Reference model: waiting line, remaining consult time per doctor, tie-break kiosk.
  entry_t m_q[$];
  int     m_timer[2];
  int     m_rr;
  int     m_served[2];
  int     m_max;

  // Monitor: compares each presented assignment with the scoreboard head.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("assign_valid_in_reset", bus.assign_valid, 1'b0);
    end else begin
      bit due;
      due = (sb.size() > 0) && (sb[0].cyc == cyc);
      check("assign_valid", bus.assign_valid, due);
      if (due) begin
        if (bus.assign_valid) begin
          check("assign_doc", bus.assign_doc, sb[0].doc);
          check("assign_id", bus.assign_id, sb[0].id);
        end
        void'(sb.pop_front());
      end else begin
        check("assign_doc_idle", bus.assign_doc, 2'b00);
      end
    end
  end

  task automatic model_step();
    int         size, g, d;
    logic [1:0] er;
    entry_t     e;
    bit         fa, fb;
    if (!rst_n) begin
      m_q.delete();
      m_timer  = '{0, 0};
      m_rr     = 0;
      m_served = '{0, 0};
      m_max    = 0;
      check("rst_doc_busy", doc_busy, 2'b00);
      check("rst_q_count", q_count, 0);
      check("rst_q_empty", q_empty, 1'b1);
      check("rst_q_full", q_full, 1'b0);
      check("rst_req_ready", bus.req_ready, 2'b00);
      check("rst_assign_doc", bus.assign_doc, 2'b00);
`ifdef SCHED_STATS_EN
      check("rst_served_a", served_a, 0);
      check("rst_served_b", served_b, 0);
      check("rst_max_occ", max_occ, 0);
`endif
      return;
    end
    size = m_q.size();
    check("doc_busy", doc_busy, {m_timer[1] != 0, m_timer[0] != 0});
    check("q_count", q_count, size);
    check("q_full", q_full, size == DEPTH);
    check("q_empty", q_empty, size == 0);
`ifdef SCHED_STATS_EN
    check("served_a", served_a, m_served[0]);
    check("served_b", served_b, m_served[1]);
    check("max_occ", max_occ, m_max);
`endif
    // Admission: one grant, tie goes to the kiosk whose turn it is.
    g = -1;
    if (size < DEPTH) begin
      if (bus.req_valid == 2'b11) g = m_rr;
      else if (bus.req_valid[0])  g = 0;
      else if (bus.req_valid[1])  g = 1;
    end
    er = 2'b00;
    if (g >= 0) er[g] = 1'b1;
    check("req_ready", bus.req_ready, er);
    // Dispatch of the head patient onto an eligible free doctor (1 = A, 2 = B).
    d = 0;
    if (size > 0) begin
      fa = (m_timer[0] == 0);
      fb = (m_timer[1] == 0);
      case (int'(m_q[0].query))
        0:       d = fa ? 1 : 0;
        1:       d = fa ? 1 : (fb ? 2 : 0);
        2:       d = fb ? 2 : (fa ? 1 : 0);
        default: d = fb ? 2 : 0;
      endcase
      if (d != 0) begin
        sb.push_back('{cyc + 1, (d == 1) ? 2'b01 : 2'b10, m_q[0].id});
        void'(m_q.pop_front());
        if (m_served[d-1] < 65535) m_served[d-1]++;
      end
    end
    if (g >= 0) begin
      e.query = query_t'(bus.req_query[2*g +: 2]);
      e.id    = bus.req_id[g*ID_W +: ID_W];
      m_q.push_back(e);
      m_rr = (g == 0) ? 1 : 0;
    end
    for (int k = 0; k < 2; k++) begin
      if (d == k + 1)             m_timer[k] = CC;
      else if (doc_release[k])    m_timer[k] = 0;
      else if (m_timer[k] > 0)    m_timer[k]--;
    end
    if (m_q.size() > m_max) m_max = m_q.size();
  endtask

  always begin
    @(negedge clk);
    #1;
    model_step();
  end

  task automatic drive(input logic [1:0] v, input logic [3:0] q, input logic [7:0] id,
                       input logic [1:0] rel);
    @(posedge clk);
    #1;
    bus.req_valid = v;
    bus.req_query = q;
    bus.req_id    = id;
    doc_release   = rel;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(2'b00, 4'h0, 8'h00, 2'b00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    sb.delete();
    bus.req_valid = 2'b00;
    doc_release   = 2'b00;
    #1;
    check("assign_drop_on_reset", bus.assign_valid, 1'b0);
    check("busy_drop_on_reset", doc_busy, 2'b00);
    repeat (3) @(negedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    bus.req_valid = 2'b00;
    bus.req_query = 4'h0;
    bus.req_id    = 8'h00;
    repeat (2) @(negedge clk);
    #3;
    rst_n = 1'b1;

    // Single kiosk0 request, query 00, id 3 -> doctor A for a full consult.
    drive(2'b01, 4'b0000, 8'h03, 2'b00);
    idle(20);

    // Both kiosks every cycle, query 00: alternating acceptance until full.
    for (int i = 0; i < 14; i++) drive(2'b11, 4'b0000, {4'(2*i+1), 4'(2*i)}, 2'b00);
    idle(145);

    // Head-of-line block: 00 waits for A while a specialist-B request sits behind it.
    drive(2'b01, 4'b0000, 8'h01, 2'b00);
    drive(2'b01, 4'b0000, 8'h02, 2'b00);
    drive(2'b01, 4'b0011, 8'h03, 2'b00);
    idle(50);

    // Preferences with both doctors free, then A-preferred while A busy.
    drive(2'b01, 4'b0001, 8'h04, 2'b00);
    drive(2'b10, 4'b1000, 8'h50, 2'b00);
    idle(20);
    drive(2'b01, 4'b0000, 8'h06, 2'b00);
    drive(2'b01, 4'b0001, 8'h07, 2'b00);
    idle(20);

    // Early release of B with a specialist-B patient waiting.
    drive(2'b01, 4'b0011, 8'h08, 2'b00);
    drive(2'b01, 4'b0011, 8'h09, 2'b00);
    idle(4);
    drive(2'b00, 4'b0000, 8'h00, 2'b10);
    idle(20);

    // Reset mid-consult with patients waiting.
    for (int i = 0; i < 5; i++) drive(2'b11, 4'b0000, {4'(i+8), 4'(i)}, 2'b00);
    idle(3);
    do_reset();
    idle(10);

    // Randomized traffic with occasional releases and resets.
    for (int i = 0; i < 4000; i++) begin
      logic [1:0] v, rel;
      v   = ($urandom_range(0, 3) == 0) ? 2'(($urandom_range(0, 3))) : 2'b00;
      rel = ($urandom_range(0, 20) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      if ((i % 8) < 3) v = 2'($urandom_range(0, 3));
      drive(v, 4'($urandom), 8'($urandom), rel);
      if ($urandom_range(0, 700) == 0) do_reset();
    end
    idle(200);

    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
